// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner front-end.
// Key indices, operator codes and FSM state encoding.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_e;

    localparam logic [3:0] KEY_FIRST_OPT = 4'd10;
    localparam logic [3:0] KEY_CMP       = 4'd14;
    localparam logic [3:0] KEY_SUBMIT    = 4'd15;

    localparam logic [2:0] OPT_CMP = 3'd5;

    function automatic logic [2:0] key_to_opt(input logic [3:0] idx);
        logic [3:0] rel;
        rel = idx - KEY_FIRST_OPT;
        if (idx == KEY_CMP) begin
            return OPT_CMP;
        end
        return rel[2:0];
    endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// Scan tick divider: one-cycle pulse every DIV clock cycles.
// Restarts its count on synchronous reset.
module scan_tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and key decode.
// Produces held-level digit / operator / submit outputs.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int clkFreq       = 50000000,
    parameter int scanFreq      = 1000,
    parameter int debounceTicks = 20
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] num,
    output logic       numPressed,
    output logic [2:0] opt,
    output logic       optPressed,
    output logic       submit,
    output logic [3:0] keyCode
);

    localparam int unsigned DIV = clkFreq / scanFreq;
    localparam int unsigned CW  = $clog2(debounceTicks);
    localparam logic [CW-1:0] CNT_LAST = CW'(debounceTicks - 1);

    logic          tick;
    logic [3:0]    col_s1_q, col_s2_q;
    state_e        state_q, state_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    num_q, num_d;
    logic [2:0]    opt_q, opt_d;
    logic          np_q, np_d;
    logic          op_q, op_d;
    logic          sub_q, sub_d;
    logic [3:0]    key_q, key_d;

    logic [3:0]    col_lo;
    logic          one_low;
    logic          all_high;
    logic [1:0]    r_idx;
    logic [1:0]    c_idx;
    logic [3:0]    row_rot;
    logic [CW-1:0] cnt_inc;

    scan_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk_i   (clk),
        .reset_i (reset),
        .tick_o  (tick)
    );

    assign col_lo   = ~col_s2_q;
    assign all_high = (col_s2_q == 4'hF);
    assign one_low  = (col_lo != 4'd0) && ((col_lo & (col_lo - 4'd1)) == 4'd0);
    assign row_rot  = {row_q[2:0], row_q[3]};
    assign cnt_inc  = cnt_q + CW'(1);

    always_comb begin
        case (row_q)
            4'b1101: r_idx = 2'd1;
            4'b1011: r_idx = 2'd2;
            4'b0111: r_idx = 2'd3;
            default: r_idx = 2'd0;
        endcase
        case (col_lo)
            4'b0010: c_idx = 2'd1;
            4'b0100: c_idx = 2'd2;
            4'b1000: c_idx = 2'd3;
            default: c_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        opt_d   = opt_q;
        np_d    = np_q;
        op_d    = op_q;
        sub_d   = sub_q;
        key_d   = key_q;
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (one_low) begin
                        idx_d   = {r_idx, c_idx};
                        pat_d   = col_s2_q;
                        cnt_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        row_d = row_rot;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s2_q == pat_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_d = ST_PRESSED;
                            key_d   = idx_q;
                            if (idx_q < KEY_FIRST_OPT) begin
                                num_d = idx_q;
                                np_d  = 1'b1;
                            end else if (idx_q == KEY_SUBMIT) begin
                                sub_d = 1'b1;
                            end else begin
                                opt_d = key_to_opt(idx_q);
                                op_d  = 1'b1;
                            end
                        end
                    end else begin
                        state_d = ST_SCAN;
                        row_d   = row_rot;
                    end
                end
                ST_PRESSED: begin
                    // Row stays frozen, so other keys cannot be seen here.
                    if (all_high) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end
                end
                ST_RELEASE: begin
                    if (all_high) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            np_d    = 1'b0;
                            op_d    = 1'b0;
                            sub_d   = 1'b0;
                            state_d = ST_SCAN;
                            row_d   = row_rot;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
            state_q  <= ST_SCAN;
            row_q    <= 4'b1110;
            pat_q    <= 4'hF;
            idx_q    <= '0;
            cnt_q    <= '0;
            num_q    <= '0;
            opt_q    <= '0;
            np_q     <= 1'b0;
            op_q     <= 1'b0;
            sub_q    <= 1'b0;
            key_q    <= '0;
        end else begin
            col_s1_q <= col;
            col_s2_q <= col_s1_q;
            state_q  <= state_d;
            row_q    <= row_d;
            pat_q    <= pat_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            opt_q    <= opt_d;
            np_q     <= np_d;
            op_q     <= op_d;
            sub_q    <= sub_d;
            key_q    <= key_d;
        end
    end

    assign row        = row_q;
    assign num        = num_q;
    assign opt        = opt_q;
    assign numPressed = np_q;
    assign optPressed = op_q;
    assign submit     = sub_q;
    assign keyCode    = key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model driven by a held-key mask,
// directed scenarios plus random key traffic against a tick-level reference.
module tb_keypad_scanner;

    localparam int CLK_F = 100;
    localparam int SCAN_F = 10;
    localparam int DB = 3;
    localparam int DIV = CLK_F / SCAN_F;

    localparam int IDLE = 0;
    localparam int CAND = 1;
    localparam int HELD = 2;
    localparam int LETGO = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] row, col, num, keyCode;
    logic [2:0] opt;
    logic numPressed, optPressed, submit;
    logic [15:0] keys = '0;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .clkFreq(CLK_F),
        .scanFreq(SCAN_F),
        .debounceTicks(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row(row),
        .col(col),
        .num(num),
        .numPressed(numPressed),
        .opt(opt),
        .optPressed(optPressed),
        .submit(submit),
        .keyCode(keyCode)
    );

    // Physical matrix: a held key pulls its column low when its row is driven.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) col = col & ~keys[r*4 +: 4];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference: tick-level view of the keypad, key-centric streak counting.
    int m_tc, m_r, m_mode, m_key, m_streak;
    logic [3:0] m_c1, m_c2, m_pat, m_num, m_kc;
    logic [2:0] m_opt;
    bit m_np, m_op, m_sub;

    function automatic int lone_col(input logic [3:0] s);
        int n = 0;
        int c = -1;
        for (int i = 0; i < 4; i++) begin
            if (!s[i]) begin
                n++;
                c = i;
            end
        end
        return (n == 1) ? c : -1;
    endfunction

    task automatic model_accept();
        m_kc = 4'(m_key);
        if (m_key <= 9) begin
            m_num = 4'(m_key);
            m_np = 1'b1;
        end else if (m_key == 15) begin
            m_sub = 1'b1;
        end else begin
            m_op = 1'b1;
            m_opt = (m_key == 14) ? 3'd5 : 3'(m_key - 10);
        end
    endtask

    task automatic model_tick(input logic [3:0] s);
        int c;
        c = lone_col(s);
        case (m_mode)
            IDLE: begin
                if (c >= 0) begin
                    m_key = m_r * 4 + c;
                    m_pat = s;
                    m_streak = 1;
                    m_mode = CAND;
                end else begin
                    m_r = (m_r + 1) % 4;
                end
            end
            CAND: begin
                if (s == m_pat) begin
                    m_streak++;
                    if (m_streak == DB) begin
                        model_accept();
                        m_mode = HELD;
                    end
                end else begin
                    m_mode = IDLE;
                    m_r = (m_r + 1) % 4;
                end
            end
            HELD: begin
                if (s == 4'hF) begin
                    m_mode = LETGO;
                    m_streak = 1;
                end
            end
            default: begin
                if (s == 4'hF) begin
                    m_streak++;
                    if (m_streak == DB) begin
                        m_np = 1'b0;
                        m_op = 1'b0;
                        m_sub = 1'b0;
                        m_mode = IDLE;
                        m_r = (m_r + 1) % 4;
                    end
                end else begin
                    m_mode = HELD;
                end
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_tc = 0;
            m_c1 = 4'hF;
            m_c2 = 4'hF;
            m_r = 0;
            m_mode = IDLE;
            m_key = 0;
            m_streak = 0;
            m_pat = 4'hF;
            m_num = 4'd0;
            m_opt = 3'd0;
            m_kc = 4'd0;
            m_np = 1'b0;
            m_op = 1'b0;
            m_sub = 1'b0;
        end else begin
            if (m_tc == DIV - 1) begin
                m_tc = 0;
                model_tick(m_c2);
            end else begin
                m_tc++;
            end
            m_c2 = m_c1;
            m_c1 = col;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic [3:0] er;
            er = ~(4'b0001 << m_r);
            chk("row", row, er);
            chk("numPressed", numPressed, m_np);
            chk("num", num, m_num);
            chk("optPressed", optPressed, m_op);
            chk("opt", opt, m_opt);
            chk("submit", submit, m_sub);
            chk("keyCode", keyCode, m_kc);
            chk("exclusive", ($countones({numPressed, optPressed, submit}) <= 1), 1);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_watch(input int n, output bit seen);
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen = seen | numPressed | optPressed | submit;
        end
    endtask

    initial begin
        bit seen;
        int waited;

        reset = 1'b1;
        hold(3);
        chk("rst_row", row, 4'hE);
        chk("rst_np", numPressed, 0);
        chk("rst_op", optPressed, 0);
        chk("rst_sub", submit, 0);
        chk("rst_num", num, 0);
        chk("rst_opt", opt, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        keys = 16'h0080;
        hold(200);
        chk("k7_np", numPressed, 1);
        chk("k7_num", num, 7);
        chk("k7_row", row, 4'hD);
        keys = '0;
        hold(100);
        chk("k7_rel", numPressed, 0);

        waited = 0;
        while (row != 4'hD && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        chk("bounce_row_seen", (row == 4'hD), 1);
        keys = 16'h0020;
        hold_watch(10, seen);
        keys = '0;
        begin
            bit seen2;
            hold_watch(80, seen2);
            chk("bounce_no_press", seen | seen2, 0);
        end

        keys = 16'h4000;
        hold(200);
        chk("k14_op", optPressed, 1);
        chk("k14_opt", opt, 5);
        keys = '0;
        hold(100);
        keys = 16'h8000;
        hold(200);
        chk("k15_sub", submit, 1);
        chk("k15_op", optPressed, 0);
        chk("k15_code", keyCode, 15);
        keys = '0;
        hold(100);

        keys = 16'h000C;
        hold_watch(150, seen);
        chk("ghost_no_press", seen, 0);
        keys = 16'h0080;
        hold(200);
        keys = keys | 16'h0004;
        hold(100);
        chk("k7k2_np", numPressed, 1);
        chk("k7k2_num", num, 7);
        keys = '0;
        hold(100);

        keys = 16'h0080;
        hold(200);
        chk("rst_mid_pre", numPressed, 1);
        reset = 1'b1;
        hold(1);
        chk("rst_mid_np", numPressed, 0);
        chk("rst_mid_row", row, 4'hE);
        reset = 1'b0;
        hold(50);
        keys = '0;
        hold(100);

        repeat (40) begin
            case ($urandom_range(0, 3))
                0: keys = '0;
                1, 2: keys = 16'(1 << $urandom_range(0, 15));
                default: keys = 16'(1 << $urandom_range(0, 15)) |
                                16'(1 << $urandom_range(0, 15));
            endcase
            hold($urandom_range(5, 120));
        end
        keys = '0;
        hold(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
